// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit.
// - FWD_* : select codes driven onto forward_a / forward_b.
// - tag_t : one pipeline tag entry (destination info plus source info for DX).
// - TAG_BUBBLE : an empty slot; every field zero.
// - is_producer : true when an entry will write the given register.
package fwd_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MW = 2'b01;
  localparam logic [1:0] FWD_EM = 2'b10;

  // Specifiers are stored zero-extended to this width so the struct does not
  // depend on the instantiating module's REG_BITS (which must not exceed it).
  localparam int TAG_REG_BITS = 5;

  typedef logic [TAG_REG_BITS-1:0] reg_id_t;

  typedef struct packed {
    logic    valid;
    logic    regWrite;
    reg_id_t rd;
    logic    isLoad;
    reg_id_t rs;
    logic    rsValid;
    reg_id_t rt;
    logic    rtValid;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  function automatic logic is_producer(input tag_t e, input reg_id_t r);
    return e.valid && e.regWrite && (e.rd == r);
  endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// Single pipeline tag entry register.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears to bubble)
//   hold     : keep the current contents (pipeline freeze)
//   bubble   : load an empty entry instead of d
//   d        : next entry contents
//   q        : registered entry
module stage_tag_reg
  import fwd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  tag_t r_tag;

  // hold dominates bubble so a frozen pipeline never loses an instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= TAG_BUBBLE;
    end else if (!hold) begin
      r_tag <= bubble ? TAG_BUBBLE : d;
    end
  end

  assign q = r_tag;

endmodule

// File: rtl/forward_ctrl.sv
// Hazard detection and EX operand forwarding control for the 5-stage pipeline.
// Tracks DX (ID/EX), XM (EX/MEM) and MW (MEM/WB) tag entries.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   ID_valid, rsValid_ID, rs_ID,
//   rtValid_ID, rt_ID, regWrite_ID,
//   rd_ID, memRead_ID              : decode-stage instruction fields
//   stall_in                       : global freeze, all entries hold
//   flush                          : squash the instruction in ID
//   forward_a, forward_b           : EX operand mux selects (registered-entry only)
//   loadUse_stall                  : hold PC/IF-ID, bubble into ID/EX
//   stallCount                     : saturating count of load-use stall cycles
module forward_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ID_valid,
  input  logic                rsValid_ID,
  input  logic                rtValid_ID,
  input  logic [REG_BITS-1:0] rs_ID,
  input  logic [REG_BITS-1:0] rt_ID,
  input  logic                regWrite_ID,
  input  logic [REG_BITS-1:0] rd_ID,
  input  logic                memRead_ID,
  input  logic                stall_in,
  input  logic                flush,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                loadUse_stall,
  output logic [CNT_BITS-1:0] stallCount
);

  tag_t    w_id;
  tag_t    w_dx;
  tag_t    w_xm;
  tag_t    w_mw;
  reg_id_t w_rs_id;
  reg_id_t w_rt_id;
  logic    w_use_rs;
  logic    w_use_rt;
  logic    w_dx_bubble;
  logic    w_unused_mw;

  logic [CNT_BITS-1:0] r_stallCount;

  assign w_rs_id = reg_id_t'(rs_ID);
  assign w_rt_id = reg_id_t'(rt_ID);

  always_comb begin
    w_id          = TAG_BUBBLE;
    w_id.valid    = ID_valid;
    w_id.regWrite = regWrite_ID;
    w_id.rd       = reg_id_t'(rd_ID);
    w_id.isLoad   = memRead_ID;
    w_id.rs       = w_rs_id;
    w_id.rsValid  = rsValid_ID;
    w_id.rt       = w_rt_id;
    w_id.rtValid  = rtValid_ID;
  end

  // ---- Load-use hazard: ID consumer against a load sitting in DX ----
  assign w_use_rs = rsValid_ID && (w_rs_id == w_dx.rd);
  assign w_use_rt = rtValid_ID && (w_rt_id == w_dx.rd);

  assign loadUse_stall = ID_valid && w_dx.valid && w_dx.regWrite && w_dx.isLoad &&
                         (w_use_rs || w_use_rt) && !flush;

  assign w_dx_bubble = flush || loadUse_stall;

  // ---- ID -> DX ----
  stage_tag_reg u_dx (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_in),
    .bubble (w_dx_bubble),
    .d      (w_id),
    .q      (w_dx)
  );

  // ---- DX -> XM ----
  stage_tag_reg u_xm (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_in),
    .bubble (1'b0),
    .d      (w_dx),
    .q      (w_xm)
  );

  // ---- XM -> MW ----
  stage_tag_reg u_mw (
    .clk    (clk),
    .rst    (rst),
    .hold   (stall_in),
    .bubble (1'b0),
    .d      (w_xm),
    .q      (w_mw)
  );

  // Source fields and the load flag are never consulted once an entry reaches MW.
  assign w_unused_mw = ^{w_mw.isLoad, w_mw.rs, w_mw.rsValid, w_mw.rt, w_mw.rtValid};

  // ---- Forwarding selects: registered entries only, EX/MEM wins ----
  always_comb begin
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    if (w_dx.valid) begin
      if (w_dx.rsValid) begin
        if (is_producer(w_xm, w_dx.rs)) begin
          forward_a = FWD_EM;
        end else if (is_producer(w_mw, w_dx.rs)) begin
          forward_a = FWD_MW;
        end
      end
      if (w_dx.rtValid) begin
        if (is_producer(w_xm, w_dx.rt)) begin
          forward_b = FWD_EM;
        end else if (is_producer(w_mw, w_dx.rt)) begin
          forward_b = FWD_MW;
        end
      end
    end
  end

  // ---- Stall performance counter, saturating at all-ones ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (loadUse_stall && !stall_in && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign stallCount = r_stallCount;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ID_valid, rsValid_ID, rtValid_ID, regWrite_ID, memRead_ID, stall_in, flush;
  logic [2:0] rs_ID, rt_ID, rd_ID;
  logic [1:0] forward_a, forward_b, fa_s, fb_s;
  logic       loadUse_stall, lu_s;
  logic [15:0] stallCount;
  logic [2:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  forward_ctrl #(.REG_BITS(3), .CNT_BITS(16)) u_dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .rsValid_ID(rsValid_ID), .rtValid_ID(rtValid_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .regWrite_ID(regWrite_ID), .rd_ID(rd_ID), .memRead_ID(memRead_ID),
    .stall_in(stall_in), .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .loadUse_stall(loadUse_stall), .stallCount(stallCount)
  );

  // Narrow counter instance: reaches its all-ones ceiling in a handful of stalls.
  forward_ctrl #(.REG_BITS(3), .CNT_BITS(3)) u_dut_sat (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .rsValid_ID(rsValid_ID), .rtValid_ID(rtValid_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .regWrite_ID(regWrite_ID), .rd_ID(rd_ID), .memRead_ID(memRead_ID),
    .stall_in(stall_in), .flush(flush), .forward_a(fa_s), .forward_b(fb_s),
    .loadUse_stall(lu_s), .stallCount(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #2;
  endtask

  task automatic set_id(input logic v, input logic rsv, input logic [2:0] rs,
                        input logic rtv, input logic [2:0] rt,
                        input logic rw, input logic [2:0] rd, input logic ld);
    ID_valid    = v;
    rsValid_ID  = rsv;
    rs_ID       = rs;
    rtValid_ID  = rtv;
    rt_ID       = rt;
    regWrite_ID = rw;
    rd_ID       = rd;
    memRead_ID  = ld;
  endtask

  task automatic idle;
    set_id(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic drain;
    idle();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    look();
    chk("rst_fa",  32'(forward_a), 0);
    chk("rst_fb",  32'(forward_b), 0);
    chk("rst_lu",  32'(loadUse_stall), 0);
    chk("rst_cnt", 32'(stallCount), 0);
    rst = 1'b0;

    // add r1 ; add r2,r1,r3
    set_id(1, 1, 3'd2, 1, 3'd3, 1, 3'd1, 0);
    tick();
    set_id(1, 1, 3'd1, 1, 3'd3, 1, 3'd2, 0);
    look();
    chk("alu_dep_no_stall", 32'(loadUse_stall), 0);
    tick();
    idle();
    look();
    chk("em_fa", 32'(forward_a), 2);
    chk("em_fb", 32'(forward_b), 0);

    // producer r4, unrelated (r7), consumer rt=r4
    drain();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0); tick();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd7, 0); tick();
    set_id(1, 1, 3'd2, 1, 3'd4, 1, 3'd3, 0); tick();
    idle();
    look();
    chk("mw_fb", 32'(forward_b), 1);
    chk("mw_fa", 32'(forward_a), 0);

    // r4 written by both XM and MW: youngest (EX/MEM) wins
    drain();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0); tick();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0); tick();
    set_id(1, 1, 3'd2, 1, 3'd4, 1, 3'd3, 0); tick();
    idle();
    look();
    chk("prio_fb", 32'(forward_b), 2);

    // Same shape but consumer does not read rt
    drain();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0); tick();
    set_id(1, 0, 3'd0, 0, 3'd4, 1, 3'd3, 0); tick();
    idle();
    look();
    chk("rtvalid_gate_fb", 32'(forward_b), 0);

    // ld r5 ; add r6,r5,r5
    drain();
    set_id(1, 1, 3'd1, 0, 3'd0, 1, 3'd5, 1); tick();
    set_id(1, 1, 3'd5, 1, 3'd5, 1, 3'd6, 0);
    look();
    chk("lu_assert", 32'(loadUse_stall), 1);
    chk("lu_cnt0",   32'(stallCount), 0);
    tick();
    look();
    chk("lu_once",    32'(loadUse_stall), 0);
    chk("lu_cnt1",    32'(stallCount), 1);
    chk("bubble_fa",  32'(forward_a), 0);
    chk("bubble_fb",  32'(forward_b), 0);
    tick();
    idle();
    look();
    // Consumer in EX: bubble in XM, the load has advanced to MW.
    chk("lu_cons_fa", 32'(forward_a), 1);
    chk("lu_cons_fb", 32'(forward_b), 1);

    // Load-use condition while flushing
    drain();
    set_id(1, 1, 3'd1, 0, 3'd0, 1, 3'd5, 1); tick();
    set_id(1, 1, 3'd5, 0, 3'd0, 1, 3'd6, 0);
    flush = 1'b1;
    look();
    chk("flush_lu", 32'(loadUse_stall), 0);
    tick();
    flush = 1'b0;
    idle();
    look();
    // Had the flushed r5 reader entered DX it would forward from the load in XM.
    chk("flush_dx_bubble_fa", 32'(forward_a), 0);
    chk("flush_cnt",          32'(stallCount), 1);

    // Freeze for three cycles with a load-use pending
    drain();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0); tick();          // prod r1
    set_id(1, 1, 3'd1, 0, 3'd0, 1, 3'd2, 0); tick();          // cons r1 -> rd r2
    set_id(1, 1, 3'd1, 0, 3'd0, 1, 3'd5, 1);                  // ld r5 reading r1
    look();
    chk("frz_pre_fa", 32'(forward_a), 2);
    tick();
    set_id(1, 1, 3'd5, 1, 3'd2, 1, 3'd6, 0);                  // reads r5, r2
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("frz_lu",  32'(loadUse_stall), 1);
      chk("frz_fa",  32'(forward_a), 1);
      chk("frz_cnt", 32'(stallCount), 1);
      tick();
    end
    stall_in = 1'b0;
    look();
    chk("resume_lu", 32'(loadUse_stall), 1);
    chk("resume_fa", 32'(forward_a), 1);
    chk("resume_cnt", 32'(stallCount), 1);
    tick();
    look();
    chk("resume_cnt2", 32'(stallCount), 2);
    chk("resume_bubble_fa", 32'(forward_a), 0);
    tick();
    idle();
    look();
    chk("resume_cons_fa", 32'(forward_a), 1);
    chk("resume_cons_fb", 32'(forward_b), 0);

    // Reset while a load-use stall is pending
    drain();
    set_id(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 1); tick();
    set_id(1, 1, 3'd5, 0, 3'd0, 1, 3'd6, 0);
    look();
    chk("prerst_lu", 32'(loadUse_stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    look();
    chk("midrst_lu",    32'(loadUse_stall), 0);
    chk("midrst_fa",    32'(forward_a), 0);
    chk("midrst_fb",    32'(forward_b), 0);
    chk("midrst_cnt",   32'(stallCount), 0);
    chk("midrst_cnt_s", 32'(cnt_s), 0);

    // Repeated "ld r5,(r5)": one stall every two cycles; narrow counter saturates at 7
    set_id(1, 1, 3'd5, 0, 3'd0, 1, 3'd5, 1);
    tick();
    for (int k = 1; k <= 9; k++) begin
      look();
      chk("sat_lu_on", 32'(loadUse_stall), 1);
      tick();
      look();
      chk("sat_cnt16", 32'(stallCount), 32'(k));
      chk("sat_cnt3",  32'(cnt_s), (k < 7) ? 32'(k) : 32'd7);
      chk("sat_lu_off", 32'(loadUse_stall), 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
